// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two master request/response ports and the
// shared memory port of mem_arbiter. The arbiter connects through the
// slave modport; the masters and the memory connect through the master
// modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] iM0Addr, iM1Addr;
  logic [DATA_W-1:0] iM0Data, iM1Data;
  logic              iM0Read, iM1Read;
  logic              iM0Write, iM1Write;
  logic [DATA_W-1:0] oM0Data, oM1Data;
  logic              oM0Rdy, oM1Rdy;
  logic              oM0Err, oM1Err;
  logic [ADDR_W-1:0] oMemAddr;
  logic [DATA_W-1:0] oMemData;
  logic [DATA_W-1:0] iMemData;
  logic              oMemRead, oMemWrite;
  logic              iMemRdy;
  logic [1:0]        oGrant;

  modport slave (
    input  iM0Addr, iM1Addr, iM0Data, iM1Data,
    input  iM0Read, iM1Read, iM0Write, iM1Write,
    output oM0Data, oM1Data, oM0Rdy, oM1Rdy, oM0Err, oM1Err,
    output oMemAddr, oMemData, oMemRead, oMemWrite, oGrant,
    input  iMemData, iMemRdy
  );

  modport master (
    output iM0Addr, iM1Addr, iM0Data, iM1Data,
    output iM0Read, iM1Read, iM0Write, iM1Write,
    input  oM0Data, oM1Data, oM0Rdy, oM1Rdy, oM0Err, oM1Err,
    input  oMemAddr, oMemData, oMemRead, oMemWrite, oGrant,
    output iMemData, iMemRdy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter in front of a single memory
// port. The winner's request is registered onto the memory bus, held until
// iMemRdy, then read data and a one-cycle ready pulse go back to the winner.
// Optional feature macro: MEM_ARB_TIMEOUT_EN adds a per-transaction wait
// counter that aborts a transaction after TIMEOUT unanswered cycles and
// flags the completion with oMxErr.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         iClk,
  input  logic         nRst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUS0 = 2'd1, BUS1 = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic                   last_q;
  logic [1:0]             rd_req, wr_req, req;
  logic                   grant_en, grant_sel, done, abort, owner, timed_out;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   rd_q, wr_q;
  logic [1:0]             grant_q, rdy_q, err_q;
  logic [1:0][DATA_W-1:0] rdata_q;

  assign rd_req = {bus.iM1Read,  bus.iM0Read};
  assign wr_req = {bus.iM1Write, bus.iM0Write};
  // A master is ignored in the cycle it sees its ready pulse; it has not
  // dropped the finished request yet.
  assign req    = (rd_req | wr_req) & ~rdy_q;
  assign owner  = (state_q == BUS1);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);
  logic [7:0] wait_q;

  // iMemRdy on the limit cycle still completes normally.
  assign timed_out = (state_q != IDLE) && !bus.iMemRdy && (wait_q == WAIT_LIMIT);

  // Wait counter: cleared at grant, counts unanswered bus cycles.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst)                                 wait_q <= '0;
    else if (grant_en)                         wait_q <= '0;
    else if (state_q != IDLE && !bus.iMemRdy)  wait_q <= wait_q + 8'd1;
  end
`else
  assign timed_out = 1'b0;
`endif

  // State register.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: grant decision in IDLE, completion/abort while on the bus.
  always_comb begin
    state_d   = state_q;
    grant_en  = 1'b0;
    grant_sel = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_en  = 1'b1;
          grant_sel = (req == 2'b11) ? ~last_q : req[1];
          state_d   = grant_sel ? BUS1 : BUS0;
        end
      end
      BUS0, BUS1: begin
        if (bus.iMemRdy) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (timed_out) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus registers, round-robin pointer and per-master responses.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      grant_q <= 2'b00;
      rdy_q   <= 2'b00;
      err_q   <= 2'b00;
      rdata_q <= '0;
    end else begin
      rdy_q <= 2'b00;
      err_q <= 2'b00;
      if (grant_en) begin
        addr_q  <= grant_sel ? bus.iM1Addr : bus.iM0Addr;
        wdata_q <= grant_sel ? bus.iM1Data : bus.iM0Data;
        // Write takes priority when a master raises both strobes.
        wr_q    <= wr_req[grant_sel];
        rd_q    <= rd_req[grant_sel] & ~wr_req[grant_sel];
        grant_q <= grant_sel ? 2'b10 : 2'b01;
      end
      if (done || abort) begin
        rd_q          <= 1'b0;
        wr_q          <= 1'b0;
        grant_q       <= 2'b00;
        last_q        <= owner;
        rdy_q[owner]  <= 1'b1;
        err_q[owner]  <= abort;
        if (done && rd_q) rdata_q[owner] <= bus.iMemData;
      end
    end
  end

  assign bus.oMemAddr  = addr_q;
  assign bus.oMemData  = wdata_q;
  assign bus.oMemRead  = rd_q;
  assign bus.oMemWrite = wr_q;
  assign bus.oGrant    = grant_q;
  assign bus.oM0Rdy    = rdy_q[0];
  assign bus.oM1Rdy    = rdy_q[1];
  assign bus.oM0Err    = err_q[0];
  assign bus.oM1Err    = err_q[1];
  assign bus.oM0Data   = rdata_q[0];
  assign bus.oM1Data   = rdata_q[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus directed corner cases and a randomized
// run against a transaction-level model of masters, memory and arbitration.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic iClk = 1'b0;
  logic nRst = 1'b0;
  always #5 iClk = ~iClk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .iClk(iClk), .nRst(nRst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  in;    // {m0r, m0w, m1r, m1w, memrdy}
    logic [31:0] mdat;
    logic [1:0]  g;
    logic [1:0]  rw;    // {oMemRead, oMemWrite}
    logic [1:0]  rdy;   // {oM1Rdy, oM0Rdy}
    logic [31:0] addr, md, d0, d1;
  } vec_t;
  vec_t tbl[15];

  // randomized-run model state
  logic        pend[2];
  int          gap[2], op[2];   // op: 0 read, 1 write, 2 read+write
  logic [31:0] raddr[2], rwdata[2], dmodel[2];
  logic [31:0] dev_mem[4], ref_mem[4];
  int          lat, waited;
  logic        last_m, r0, r1, free_b, rdy_b, w;
  logic [1:0]  own_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive_m(input int m, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      bus.iM0Read = rd; bus.iM0Write = wr; bus.iM0Addr = a; bus.iM0Data = d;
    end else begin
      bus.iM1Read = rd; bus.iM1Write = wr; bus.iM1Addr = a; bus.iM1Data = d;
    end
  endtask

  task automatic do_reset();
    drive_m(0, 0, 0, 0, 0);
    drive_m(1, 0, 0, 0, 0);
    bus.iMemRdy = 1'b0;
    bus.iMemData = '0;
    nRst = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    nRst = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " grant"}, bus.oGrant, 0);
    chk({tag, " strobes"}, {bus.oMemRead, bus.oMemWrite}, 0);
    chk({tag, " addr"}, bus.oMemAddr, 0);
    chk({tag, " wdata"}, bus.oMemData, 0);
    chk({tag, " rdy/err"}, {bus.oM1Rdy, bus.oM0Rdy, bus.oM1Err, bus.oM0Err}, 0);
    chk({tag, " rdata"}, {bus.oM1Data, bus.oM0Data}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // ---------------- reset values ----------------
    do_reset();
    nRst = 1'b0;
    #1;
    chk_all_zero("reset");
    tick();
    nRst = 1'b1;

    // ---------------- vector table ----------------
    tbl[0]  = '{5'b01100, 32'h0,    2'b01, 2'b01, 2'b00, 32'h1004, 32'h1,  32'h0, 32'h0};
    tbl[1]  = '{5'b01101, 32'h0,    2'b00, 2'b00, 2'b01, 32'h1004, 32'h1,  32'h0, 32'h0};
    tbl[2]  = '{5'b00100, 32'h0,    2'b10, 2'b10, 2'b00, 32'h1000, 32'hA5, 32'h0, 32'h0};
    tbl[3]  = '{5'b00101, 32'h2,    2'b00, 2'b00, 2'b10, 32'h1000, 32'hA5, 32'h0, 32'h2};
    tbl[4]  = '{5'b01110, 32'h0,    2'b01, 2'b01, 2'b00, 32'h1004, 32'h1,  32'h0, 32'h2};
    tbl[5]  = '{5'b01111, 32'h0,    2'b00, 2'b00, 2'b01, 32'h1004, 32'h1,  32'h0, 32'h2};
    tbl[6]  = '{5'b00110, 32'h0,    2'b10, 2'b01, 2'b00, 32'h1000, 32'hA5, 32'h0, 32'h2};
    tbl[7]  = '{5'b00111, 32'hDEAD, 2'b00, 2'b00, 2'b10, 32'h1000, 32'hA5, 32'h0, 32'h2};
    tbl[8]  = '{5'b00001, 32'h0,    2'b00, 2'b00, 2'b00, 32'h1000, 32'hA5, 32'h0, 32'h2};
    tbl[9]  = '{5'b10100, 32'h0,    2'b01, 2'b10, 2'b00, 32'h1004, 32'h1,  32'h0, 32'h2};
    tbl[10] = '{5'b10101, 32'h3,    2'b00, 2'b00, 2'b01, 32'h1004, 32'h1,  32'h3, 32'h2};
    tbl[11] = '{5'b10000, 32'h0,    2'b00, 2'b00, 2'b00, 32'h1004, 32'h1,  32'h3, 32'h2};
    tbl[12] = '{5'b10000, 32'h0,    2'b01, 2'b10, 2'b00, 32'h1004, 32'h1,  32'h3, 32'h2};
    tbl[13] = '{5'b10001, 32'h4,    2'b00, 2'b00, 2'b01, 32'h1004, 32'h1,  32'h4, 32'h2};
    tbl[14] = '{5'b00000, 32'h0,    2'b00, 2'b00, 2'b00, 32'h1004, 32'h1,  32'h4, 32'h2};

    bus.iM0Addr = 32'h1004; bus.iM0Data = 32'h1;
    bus.iM1Addr = 32'h1000; bus.iM1Data = 32'hA5;
    for (int i = 0; i < 15; i++) begin
      {bus.iM0Read, bus.iM0Write, bus.iM1Read, bus.iM1Write, bus.iMemRdy} = tbl[i].in;
      bus.iMemData = tbl[i].mdat;
      tick();
      chk($sformatf("vec%0d grant", i), bus.oGrant, tbl[i].g);
      chk($sformatf("vec%0d strobes", i), {bus.oMemRead, bus.oMemWrite}, tbl[i].rw);
      chk($sformatf("vec%0d rdy", i), {bus.oM1Rdy, bus.oM0Rdy}, tbl[i].rdy);
      chk($sformatf("vec%0d addr", i), bus.oMemAddr, tbl[i].addr);
      chk($sformatf("vec%0d wdata", i), bus.oMemData, tbl[i].md);
      chk($sformatf("vec%0d d0", i), bus.oM0Data, tbl[i].d0);
      chk($sformatf("vec%0d d1", i), bus.oM1Data, tbl[i].d1);
    end

    // ---------------- single read, ready in first strobe cycle ----------------
    do_reset();
    drive_m(0, 1, 0, 32'h1000, 0);
    tick();
    chk("single rd strobe", {bus.oMemRead, bus.oGrant}, 3'b101);
    chk("single rd early rdy", bus.oM0Rdy, 0);
    bus.iMemRdy = 1'b1; bus.iMemData = 32'h2;
    tick();
    chk("single rd strobe off", bus.oMemRead, 0);
    chk("single rd rdy", bus.oM0Rdy, 1);
    chk("single rd data", bus.oM0Data, 32'h2);
    drive_m(0, 0, 0, 0, 0);
    bus.iMemRdy = 1'b0;
    tick();
    chk("single rd pulse width", bus.oM0Rdy, 0);

    // ---------------- wait states ----------------
    do_reset();
    drive_m(0, 0, 1, 32'h2000, 32'h55);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wait addr", bus.oMemAddr, 32'h2000);
      chk("wait wdata", bus.oMemData, 32'h55);
      chk("wait strobes", {bus.oMemRead, bus.oMemWrite, bus.oGrant}, 4'b0101);
      chk("wait rdy", bus.oM0Rdy, 0);
    end
    bus.iMemRdy = 1'b1;
    tick();
    chk("wait done rdy", {bus.oM0Rdy, bus.oMemWrite}, 2'b10);
    drive_m(0, 0, 0, 0, 0);
    bus.iMemRdy = 1'b0;
    tick();
    chk("wait no dup", {bus.oM0Rdy, bus.oGrant, bus.oMemWrite}, 0);
    tick();
    chk("wait still idle", bus.oGrant, 0);

    // ---------------- reset mid-transaction ----------------
    do_reset();
    drive_m(0, 1, 0, 32'h3000, 32'h77);
    tick();
    chk("rst pre grant", bus.oGrant, 2'b01);
    #2;
    nRst = 1'b0;
    #1;
    chk_all_zero("rst async");
    tick();
    chk("rst no rdy", bus.oM0Rdy, 0);
    nRst = 1'b1;
    tick();
    chk("rst regrant", {bus.oGrant, bus.oMemRead}, 3'b011);
    chk("rst regrant addr", bus.oMemAddr, 32'h3000);
    bus.iMemRdy = 1'b1; bus.iMemData = 32'h99;
    tick();
    chk("rst served", {bus.oM0Rdy, bus.oM0Err}, 2'b10);
    chk("rst data", bus.oM0Data, 32'h99);
    drive_m(0, 0, 0, 0, 0);
    bus.iMemRdy = 1'b0;
    tick();

    // ---------------- timeout ----------------
    do_reset();
    drive_m(0, 1, 0, 32'h4000, 0);
    drive_m(1, 1, 0, 32'h4004, 0);
    tick();
    chk("to grant m0", bus.oGrant, 2'b01);
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("to waiting", {bus.oGrant, bus.oM0Rdy, bus.oM0Err}, 4'b0100);
    end
    tick();
    chk("to abort", {bus.oM0Rdy, bus.oM0Err, bus.oGrant, bus.oMemRead}, 5'b11000);
    chk("to data kept", bus.oM0Data, 0);
    drive_m(0, 0, 0, 0, 0);
    tick();
    chk("to m1 served", {bus.oGrant, bus.oM0Rdy, bus.oM0Err}, 4'b1000);
    bus.iMemRdy = 1'b1; bus.iMemData = 32'h5;
    tick();
    chk("to m1 done", {bus.oM1Rdy, bus.oM1Err}, 2'b10);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("noto waiting", {bus.oGrant, bus.oM0Rdy, bus.oM0Err, bus.oMemRead}, 5'b01001);
    end
    bus.iMemRdy = 1'b1; bus.iMemData = 32'h5;
    tick();
    chk("noto done", {bus.oM0Rdy, bus.oM0Err}, 2'b10);
`endif
    drive_m(0, 0, 0, 0, 0);
    drive_m(1, 0, 0, 0, 0);
    bus.iMemRdy = 1'b0;
    tick();

    // ---------------- randomized run vs. transaction model ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dev_mem[i] = 32'h1111_0000 + 32'(i);
      ref_mem[i] = dev_mem[i];
    end
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; gap[m] = 0; op[m] = 0; dmodel[m] = '0;
      raddr[m] = '0; rwdata[m] = '0;
    end
    last_m = 1'b1; lat = 0; waited = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (gap[m] > 0) gap[m]--;
        else if (!pend[m] && $urandom_range(0, 2) != 0) begin
          pend[m]   = 1'b1;
          op[m]     = int'($urandom_range(0, 2));
          raddr[m]  = 32'h100 + 32'(4 * $urandom_range(0, 3));
          rwdata[m] = $urandom;
        end
        drive_m(m, pend[m] && op[m] != 1, pend[m] && op[m] != 0, raddr[m], rwdata[m]);
      end
      bus.iMemRdy = 1'b0;
      bus.iMemData = $urandom;
      if (bus.oGrant != 2'b00 && waited == lat) begin
        bus.iMemRdy = 1'b1;
        if (bus.oMemWrite) dev_mem[bus.oMemAddr[3:2]] = bus.oMemData;
        else               bus.iMemData = dev_mem[bus.oMemAddr[3:2]];
      end
      r0 = pend[0]; r1 = pend[1];
      free_b = (bus.oGrant == 2'b00);
      rdy_b  = bus.iMemRdy;
      own_b  = bus.oGrant;
      tick();
      if (free_b) begin
        if (r0 || r1) begin
          w = (r0 && r1) ? !last_m : r1;
          chk("rnd grant", bus.oGrant, w ? 2'b10 : 2'b01);
          chk("rnd addr", bus.oMemAddr, raddr[w]);
          chk("rnd strobe", {bus.oMemRead, bus.oMemWrite}, (op[w] == 0) ? 2'b10 : 2'b01);
          if (op[w] != 0) chk("rnd wdata", bus.oMemData, rwdata[w]);
          lat = int'($urandom_range(0, 4));
          waited = 0;
        end else begin
          chk("rnd idle", bus.oGrant, 0);
        end
        chk("rnd no rdy", {bus.oM1Rdy, bus.oM0Rdy}, 0);
      end else if (rdy_b) begin
        w = own_b[1];
        chk("rnd rdy", {bus.oM1Rdy, bus.oM0Rdy}, w ? 2'b10 : 2'b01);
        chk("rnd release", {bus.oGrant, bus.oMemRead, bus.oMemWrite}, 0);
        chk("rnd err", {bus.oM1Err, bus.oM0Err}, 0);
        if (op[w] == 0) dmodel[w] = ref_mem[raddr[w][3:2]];
        else            ref_mem[raddr[w][3:2]] = rwdata[w];
        chk("rnd data0", bus.oM0Data, dmodel[0]);
        chk("rnd data1", bus.oM1Data, dmodel[1]);
        pend[w] = 1'b0;
        gap[w]  = 1 + int'($urandom_range(0, 2));
        last_m  = w;
      end else begin
        waited++;
        chk("rnd hold", bus.oGrant, own_b);
        chk("rnd hold rdy", {bus.oM1Rdy, bus.oM0Rdy}, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
